// File: rtl/fifo_lane.sv
// Single-lane synchronous FIFO feeding one input of the L1 mux.
// Registered read port, occupancy-based status flags and a sticky overflow flag.
module fifo_lane #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              validIn,
  input  logic              pop,
  output logic [DATA_W-1:0] dataOut,
  output logic              validOut,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic push_ok;
  logic pop_ok;

  // Acceptance is judged on the flags of the current count, so a pop on a full
  // FIFO does not make room for a push on the same edge.
  assign push_ok = validIn && !full;
  assign pop_ok  = pop && !empty;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Storage kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push_ok && reset) begin
      mem[wr_ptr] <= dataIn;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dataOut  <= '0;
      validOut <= 1'b0;
      error    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end

      if (pop_ok) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        dataOut  <= mem[rd_ptr];
        validOut <= 1'b1;
      end else begin
        validOut <= 1'b0;
      end

      if (validIn && full) begin
        error <= 1'b1;
      end

      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_lane.sv
// Directed bench for fifo_lane: stimulus queues expected read data, a monitor
// compares each validOut word against that queue.
module tb_fifo_lane;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] dataIn = 8'h00;
  logic       validIn = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] dataOut;
  logic       validOut;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       error;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  fifo_lane #(.DATA_W(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) dut (
    .clk(clk),
    .reset(reset),
    .dataIn(dataIn),
    .validIn(validIn),
    .pop(pop),
    .dataOut(dataOut),
    .validOut(validOut),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .error(error)
  );

  always #5 clk = ~clk;

  // Monitor: every validOut cycle must match the oldest expected word.
  always @(negedge clk) begin
    if (validOut) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: dataOut=%02h with no pop outstanding", dataOut);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (dataOut !== e) begin
          errors++;
          $display("FAIL read_data: got %02h expected %02h", dataOut, e);
        end else begin
          $display("read  %02h ok", dataOut);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  // Flags packed as {empty, almost_empty, full, almost_full, error}.
  task automatic chk_flags(input string name, input logic [4:0] req);
    chk(name, {27'd0, empty, almost_empty, full, almost_full, error}, {27'd0, req});
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic p, input logic r);
    @(negedge clk);
    validIn = v;
    dataIn  = d;
    pop     = p;
    reset   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b1);
  endtask

  task automatic pop_expect(input logic [7:0] d);
    exp_q.push_back(d);
    step(1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset and idle
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    idle(); idle(); idle();
    chk("reset_dataOut", {24'd0, dataOut}, 32'h00);
    chk("reset_validOut", {31'd0, validOut}, 32'd0);
    chk_flags("reset_flags", 5'b11000);

    // Basic push/pop ordering
    push(8'h11);
    chk_flags("one_entry_flags", 5'b01000);
    push(8'h22);
    push(8'h33);
    chk_flags("three_entry_flags", 5'b00000);
    pop_expect(8'h11);
    pop_expect(8'h22);
    pop_expect(8'h33);
    chk_flags("drained_flags", 5'b11000);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("pop_empty_validOut", {31'd0, validOut}, 32'd0);
    chk("pop_empty_keeps_dataOut", {24'd0, dataOut}, 32'h33);
    chk_flags("pop_empty_flags", 5'b11000);

    // Fill, overflow, drain
    for (int i = 0; i < 8; i++) begin
      push(8'hA0 + 8'(i));
      if (i == 4) chk_flags("five_entries", 5'b00000);
      if (i == 5) chk_flags("six_entries_af", 5'b00010);
      if (i == 6) chk_flags("seven_entries", 5'b00010);
    end
    chk_flags("full_flags", 5'b00110);
    push(8'hFF);
    chk_flags("overflow_flags", 5'b00111);
    // Push while full with simultaneous pop: push still dropped
    exp_q.push_back(8'hA0);
    step(1'b1, 8'hFE, 1'b1, 1'b1);
    chk_flags("full_push_pop_flags", 5'b00011);
    for (int i = 1; i < 8; i++) pop_expect(8'hA0 + 8'(i));
    chk_flags("overflow_drained", 5'b11001);

    // Steady state push+pop across pointer wrap, count held at 4
    for (int i = 0; i < 4; i++) push(8'hB0 + 8'(i));
    for (int i = 0; i < 12; i++) begin
      if (i < 4) exp_q.push_back(8'hB0 + 8'(i));
      else       exp_q.push_back(8'hC0 + 8'(i - 4));
      step(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b1);
      if (i == 0 || i == 11) chk_flags("streaming_flags", 5'b00001);
    end
    for (int i = 8; i < 12; i++) pop_expect(8'hC0 + 8'(i));
    chk_flags("stream_drained", 5'b11001);

    // Push and pop on an empty FIFO
    step(1'b1, 8'h5A, 1'b1, 1'b1);
    chk("empty_pushpop_validOut", {31'd0, validOut}, 32'd0);
    chk_flags("empty_pushpop_flags", 5'b01001);
    pop_expect(8'h5A);
    chk_flags("after_5a_flags", 5'b11001);

    // Reset mid-transfer with push and pop asserted
    for (int i = 0; i < 5; i++) push(8'hD0 + 8'(i));
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("midreset_dataOut", {24'd0, dataOut}, 32'h00);
    chk("midreset_validOut", {31'd0, validOut}, 32'd0);
    chk_flags("midreset_flags", 5'b11000);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("post_reset_pop_validOut", {31'd0, validOut}, 32'd0);
    chk_flags("post_reset_flags", 5'b11000);

    idle(); idle();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_lane.md
FIFO_LANE -- requirements
Module: fifo_lane

Interface
REQ-001 Parameter DATA_W, default 8, data width of one lane in bits.
REQ-002 Parameter DEPTH, default 8, number of entries; power of two.
REQ-003 Parameter AF_THRESH, default 6, occupancy at or above which almost_full asserts.
REQ-004 Parameter AE_THRESH, default 2, occupancy at or below which almost_empty asserts.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-007 dataIn  input  DATA_W  write data from the upstream source.
REQ-008 validIn  input  1  push request; dataIn is qualified when high.
REQ-009 pop  input  1  read request from the downstream mux stage.
REQ-010 dataOut  output  DATA_W  registered read data, fed to one dataIn lane of the L1 mux.
REQ-011 validOut  output  1  registered; high for exactly the cycle after an accepted pop.
REQ-012 full  output  1  occupancy == DEPTH.
REQ-013 empty  output  1  occupancy == 0.
REQ-014 almost_full  output  1  occupancy >= AF_THRESH.
REQ-015 almost_empty  output  1  occupancy <= AE_THRESH.
REQ-016 error  output  1  sticky overflow indicator.

Function
REQ-017 Storage shall be a DEPTH x DATA_W array with write pointer, read pointer (log2(DEPTH) bits, wrapping from DEPTH-1 to 0) and occupancy count (log2(DEPTH)+1 bits).
REQ-018 Push accepted on a rising edge iff validIn=1 and full=0 at that edge: mem[wr_ptr]<=dataIn, wr_ptr increments.
REQ-019 Pop accepted on a rising edge iff pop=1 and empty=0 at that edge: dataOut<=mem[rd_ptr], validOut<=1, rd_ptr increments.
REQ-020 Cycle with no accepted pop: validOut<=0, dataOut holds its previous value.
REQ-021 Read latency: word pushed at edge N is first poppable at edge N+1 and appears on dataOut/validOut after edge N+1; no write-to-read bypass.
REQ-022 Simultaneous accepted push and pop: count unchanged, both pointers advance.
REQ-023 Push while full is rejected even if pop is accepted the same edge; data dropped, error<=1.
REQ-024 Push+pop while empty: push accepted, pop ignored, validOut<=0, count becomes 1.
REQ-025 Pop while empty: ignored, no pointer change, validOut<=0, error unaffected.
REQ-026 error, once set, remains 1 until reset.
REQ-027 full, empty, almost_full, almost_empty are decoded combinationally from the registered count and therefore reflect the state after the most recent edge.
REQ-028 Count shall never exceed DEPTH nor underflow below 0.
REQ-029 FIFO order preserved: words leave in exactly the order accepted.

Reset
REQ-030 On a rising edge with reset=0: pointers and count <=0, dataOut<=0, validOut<=0, error<=0; empty=1, almost_empty=1, full=0, almost_full=0.
REQ-031 Reset overrides push and pop on the same edge; in-flight contents are discarded.
REQ-032 Reset asserted mid-transfer: the first edge with reset=1 afterwards behaves as from an empty FIFO.

Verification
REQ-033 Reset then idle 3 cycles -> dataOut=0x00, validOut=0, empty=1, almost_empty=1, error=0.
REQ-034 Push 0x11,0x22,0x33 on consecutive edges, then pop 3 edges -> dataOut 0x11,0x22,0x33 with validOut=1 each cycle after pop; then empty=1.
REQ-035 Push 8 words 0xA0..0xA7 -> almost_full=1 after 6th, full=1 after 8th; 9th push 0xFF -> error=1, count stays 8; drain returns 0xA0..0xA7, never 0xFF.
REQ-036 Fill 4 entries, then push+pop every edge for 12 cycles (pointer wrap) -> count stays 4, output sequence matches input order exactly.
REQ-037 Empty FIFO, push 0x5A and pop same edge -> validOut=0 next cycle, count=1; pop next edge -> dataOut=0x5A, validOut=1.
REQ-038 Load 5 words, assert reset=0 for one edge with push+pop high -> all outputs at reset values, error=0, empty=1; subsequent pop yields validOut=0.
